// File: rtl/cpu_pkg.sv
// Shared RV32I store-stage definitions: funct3 codes, write FSM encoding,
// default bus timeout and the retirement record carried across a store.
package cpu_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int TIMEOUT_DEF = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        exc_to;
  } wb_ent_t;

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/mem_wr_if.sv
// Valid/ready memory write port between the store stage and the data memory.
interface mem_wr_if;
  logic [31:0] WADDR;
  logic [3:0]  WSTRB;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;

  modport master (output WADDR, WSTRB, WDATA, WVALID, input WREADY);
  modport slave  (input WADDR, WSTRB, WDATA, WVALID, output WREADY);
endinterface

// File: rtl/store_align.sv
// Combinational store lane alignment: byte strobes, lane-replicated data and
// misalignment detect from funct3 and the low address bits.
module store_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  output logic [3:0]  strb,
  output logic [31:0] data_out,
  output logic        misalign
);

  always_comb begin
    strb     = 4'b0000;
    data_out = data_in;
    misalign = 1'b0;
    case (funct3)
      F3_SB: begin
        strb     = 4'b0001 << addr_lo;
        data_out = {4{data_in[7:0]}};
      end
      F3_SH: begin
        strb     = 4'b0011 << addr_lo;
        data_out = {2{data_in[15:0]}};
        misalign = addr_lo[0];
      end
      F3_SW: begin
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wr.sv
// RV32I store-side memory stage: issues one aligned bus write per store,
// stalls upstream until it completes or times out, then retires to write-back.
module mem_wr
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_INST,
  input  logic        M_VALID,
  input  logic [4:0]  M_REG_D,
  input  logic [31:0] M_REG_D_V,
  input  logic        M_STORE_EN,
  input  logic [31:0] M_STORE_ADDR,
  input  logic [31:0] M_STORE_DATA,
  input  logic [2:0]  M_STORE_FUNCT3,
  input  logic        STALL,
  output logic        STALL_REQ,
  mem_wr_if.master    MEM,
  output logic [31:0] W_PC,
  output logic [31:0] W_INST,
  output logic        W_VALID,
  output logic [4:0]  W_REG_D,
  output logic [31:0] W_REG_D_V,
  output logic        W_EXC_MISALIGN,
  output logic        W_EXC_TIMEOUT
);

  wr_state_e   state, state_nxt;
  logic [15:0] cnt;
  logic        pend;
  wb_ent_t     lat, ret;

  logic [3:0]  al_strb;
  logic [31:0] al_data;
  logic        al_mis;

  logic is_st, hs, tmo, done;
  logic start, ld_m, ld_lat, set_pend, bubble;

  store_align u_align (
    .funct3   (M_STORE_FUNCT3),
    .addr_lo  (M_STORE_ADDR[1:0]),
    .data_in  (M_STORE_DATA),
    .strb     (al_strb),
    .data_out (al_data),
    .misalign (al_mis)
  );

  always_comb begin
    is_st = M_VALID & M_STORE_EN & is_store_f3(M_STORE_FUNCT3);
    hs    = (state == ST_REQ) & MEM.WVALID & MEM.WREADY;
    tmo   = (state == ST_REQ) & ~MEM.WREADY & (cnt == 16'(TIMEOUT - 1));
    done  = hs | tmo;
    ret   = lat;
    if (state == ST_REQ) ret.exc_to = tmo;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ:  if (done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A retirement that meets a downstream stall parks in the pending slot;
  // M_* still shows that store until the slot drains, so hold upstream too.
  always_comb begin
    STALL_REQ = 1'b0;
    start     = 1'b0;
    ld_m      = 1'b0;
    ld_lat    = 1'b0;
    set_pend  = 1'b0;
    bubble    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          STALL_REQ = STALL;
          ld_lat    = ~STALL;
        end else if (STALL) begin
          STALL_REQ = M_VALID & M_STORE_EN;
        end else if (is_st & ~al_mis) begin
          STALL_REQ = 1'b1;
          start     = 1'b1;
          bubble    = 1'b1;
        end else begin
          ld_m = 1'b1;
        end
      end
      ST_REQ: begin
        STALL_REQ = ~done | STALL;
        if (done) begin
          set_pend = STALL;
          ld_lat   = ~STALL;
        end else if (!STALL) begin
          bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt            <= '0;
      pend           <= 1'b0;
      lat            <= '0;
      MEM.WVALID     <= 1'b0;
      MEM.WADDR      <= '0;
      MEM.WSTRB      <= '0;
      MEM.WDATA      <= '0;
      W_PC           <= '0;
      W_INST         <= '0;
      W_VALID        <= 1'b0;
      W_REG_D        <= '0;
      W_REG_D_V      <= '0;
      W_EXC_MISALIGN <= 1'b0;
      W_EXC_TIMEOUT  <= 1'b0;
    end else begin
      cnt <= (state == ST_REQ && !done) ? cnt + 16'd1 : 16'd0;

      if (start) begin
        MEM.WVALID <= 1'b1;
        MEM.WADDR  <= {M_STORE_ADDR[31:2], 2'b00};
        MEM.WSTRB  <= al_strb;
        MEM.WDATA  <= al_data;
        lat        <= '{pc: M_PC, inst: M_INST, rd: M_REG_D, rdv: M_REG_D_V, exc_to: 1'b0};
      end else if (done) begin
        MEM.WVALID <= 1'b0;
      end

      if (set_pend) begin
        pend       <= 1'b1;
        lat.exc_to <= tmo;
      end else if (ld_lat) begin
        pend <= 1'b0;
      end

      if (ld_m) begin
        W_PC           <= M_PC;
        W_INST         <= M_INST;
        W_VALID        <= M_VALID;
        W_REG_D        <= M_REG_D;
        W_REG_D_V      <= M_REG_D_V;
        W_EXC_MISALIGN <= is_st & al_mis;
        W_EXC_TIMEOUT  <= 1'b0;
      end else if (ld_lat) begin
        W_PC           <= ret.pc;
        W_INST         <= ret.inst;
        W_VALID        <= 1'b1;
        W_REG_D        <= ret.rd;
        W_REG_D_V      <= ret.rdv;
        W_EXC_MISALIGN <= 1'b0;
        W_EXC_TIMEOUT  <= ret.exc_to;
      end else if (bubble) begin
        W_VALID        <= 1'b0;
        W_EXC_MISALIGN <= 1'b0;
        W_EXC_TIMEOUT  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wr.sv
// Directed bench for mem_wr: table of single-cycle vectors plus hand-written
// multi-cycle store, timeout, downstream-stall and reset-abort sequences.
module tb_mem_wr;
  import cpu_pkg::*;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] M_PC, M_INST, M_REG_D_V, M_STORE_ADDR, M_STORE_DATA;
  logic        M_VALID, M_STORE_EN, STALL, STALL_REQ;
  logic [4:0]  M_REG_D;
  logic [2:0]  M_STORE_FUNCT3;
  logic [31:0] W_PC, W_INST, W_REG_D_V;
  logic        W_VALID, W_EXC_MISALIGN, W_EXC_TIMEOUT;
  logic [4:0]  W_REG_D;

  mem_wr_if mem ();

  mem_wr #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_STORE_EN(M_STORE_EN), .M_STORE_ADDR(M_STORE_ADDR),
    .M_STORE_DATA(M_STORE_DATA), .M_STORE_FUNCT3(M_STORE_FUNCT3),
    .STALL(STALL), .STALL_REQ(STALL_REQ), .MEM(mem.master),
    .W_PC(W_PC), .W_INST(W_INST), .W_VALID(W_VALID), .W_REG_D(W_REG_D),
    .W_REG_D_V(W_REG_D_V), .W_EXC_MISALIGN(W_EXC_MISALIGN), .W_EXC_TIMEOUT(W_EXC_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int writes = 0;

  always @(posedge CLK) if (mem.WVALID && mem.WREADY) writes <= writes + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic vld, input logic [4:0] rd,
                       input logic [31:0] rdv, input logic st, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] f3);
    M_PC = pc; M_INST = 32'h0000_0013 ^ pc; M_VALID = vld; M_REG_D = rd; M_REG_D_V = rdv;
    M_STORE_EN = st; M_STORE_ADDR = addr; M_STORE_DATA = data; M_STORE_FUNCT3 = f3;
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] pc, input int waits, input logic [31:0] e_addr,
                           input logic [3:0] e_strb, input logic [31:0] e_data);
    int sr = 0;
    int w0 = writes;
    drive(pc, 1'b1, 5'd0, 32'h0, 1'b1, addr, data, f3);
    STALL = 1'b0; mem.WREADY = 1'b0;
    #1;
    if (STALL_REQ) sr++;
    tick;
    chk("req_wvalid", mem.WVALID, 1);
    chk("req_waddr", mem.WADDR, e_addr);
    chk("req_wstrb", mem.WSTRB, e_strb);
    chk("req_wdata", mem.WDATA, e_data);
    chk("req_bubble", W_VALID, 0);
    for (int i = 0; i < waits; i++) begin
      if (STALL_REQ) sr++;
      tick;
      chk("hold_wvalid", mem.WVALID, 1);
      chk("hold_wdata", mem.WDATA, e_data);
    end
    mem.WREADY = 1'b1;
    #1;
    chk("hs_stall_req", STALL_REQ, 0);
    tick;
    mem.WREADY = 1'b0; M_VALID = 1'b0; M_STORE_EN = 1'b0;
    chk("ret_valid", W_VALID, 1);
    chk("ret_pc", W_PC, pc);
    chk("ret_exc", {W_EXC_MISALIGN, W_EXC_TIMEOUT}, 0);
    chk("wvalid_drop", mem.WVALID, 0);
    chk("stall_req_cycles", sr, waits + 1);
    chk("one_write", writes - w0, 1);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        e_sreq;
    logic        e_wv;
    logic        e_mis;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n, w0;
    vt[0] = '{32'h100, 1'b1, 5'd5, 32'h12, 1'b0, 32'h0,    32'h0,    F3_SB,  1'b0, 1'b1, 1'b0};
    vt[1] = '{32'h104, 1'b1, 5'd0, 32'h0,  1'b1, 32'h2001, 32'h1234, F3_SH,  1'b0, 1'b1, 1'b1};
    vt[2] = '{32'h108, 1'b1, 5'd0, 32'h0,  1'b1, 32'h3002, 32'h5678, F3_SW,  1'b0, 1'b1, 1'b1};
    vt[3] = '{32'h10c, 1'b0, 5'd7, 32'h55, 1'b0, 32'h0,    32'h0,    F3_SB,  1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h110, 1'b1, 5'd9, 32'h77, 1'b1, 32'h40,   32'hff,   3'b100, 1'b0, 1'b1, 1'b0};

    RST = 1'b1; STALL = 1'b0; mem.WREADY = 1'b0;
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick; tick;
    chk("rst_w_valid", W_VALID, 0);
    chk("rst_w_pc", W_PC, 0);
    chk("rst_w_rdv", W_REG_D_V, 0);
    chk("rst_w_exc", {W_EXC_MISALIGN, W_EXC_TIMEOUT}, 0);
    chk("rst_mem_wvalid", mem.WVALID, 0);
    chk("rst_mem_waddr", mem.WADDR, 0);
    chk("rst_mem_wdata", {mem.WDATA[31:4], mem.WSTRB}, 0);
    chk("rst_stall_req", STALL_REQ, 0);
    RST = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].pc, vt[i].vld, vt[i].rd, vt[i].rdv, vt[i].st, vt[i].addr, vt[i].data, vt[i].f3);
      #1;
      chk($sformatf("v%0d_stall_req", i), STALL_REQ, vt[i].e_sreq);
      tick;
      chk($sformatf("v%0d_w_valid", i), W_VALID, vt[i].e_wv);
      chk($sformatf("v%0d_w_pc", i), W_PC, vt[i].pc);
      chk($sformatf("v%0d_w_rd", i), W_REG_D, vt[i].rd);
      chk($sformatf("v%0d_w_rdv", i), W_REG_D_V, vt[i].rdv);
      chk($sformatf("v%0d_misalign", i), W_EXC_MISALIGN, vt[i].e_mis);
      chk($sformatf("v%0d_mem_wvalid", i), mem.WVALID, 0);
    end
    chk("table_no_writes", writes, 0);

    run_store(F3_SB, 32'h2003, 32'hAABBCCDD, 32'h200, 3, 32'h2000, 4'b1000, 32'hDDDDDDDD);
    run_store(F3_SH, 32'h2002, 32'h0000BEEF, 32'h204, 0, 32'h2000, 4'b1100, 32'hBEEFBEEF);
    run_store(F3_SW, 32'h5004, 32'h01020304, 32'h208, 1, 32'h5004, 4'b1111, 32'h01020304);

    // timeout: WREADY never comes
    w0 = writes;
    drive(32'h300, 1'b1, 5'd0, 32'h0, 1'b1, 32'h3000, 32'hCAFEF00D, F3_SW);
    tick;
    n = 0;
    for (int i = 0; i < 20 && mem.WVALID; i++) begin
      n++;
      tick;
    end
    M_VALID = 1'b0; M_STORE_EN = 1'b0;
    chk("to_wvalid_cycles", n, TO);
    chk("to_w_valid", W_VALID, 1);
    chk("to_exc_timeout", W_EXC_TIMEOUT, 1);
    chk("to_exc_misalign", W_EXC_MISALIGN, 0);
    chk("to_w_pc", W_PC, 32'h300);
    chk("to_no_write", writes - w0, 0);
    tick;
    chk("to_flag_clears", W_EXC_TIMEOUT, 0);

    // handshake while downstream stalled for two cycles
    w0 = writes;
    drive(32'h400, 1'b1, 5'd0, 32'h0, 1'b1, 32'h0400, 32'h11223344, F3_SW);
    tick;
    STALL = 1'b1; mem.WREADY = 1'b1;
    #1;
    chk("st_hs_stall_req", STALL_REQ, 1);
    tick;
    mem.WREADY = 1'b0;
    chk("st_wvalid_drop", mem.WVALID, 0);
    chk("st_one_write", writes - w0, 1);
    chk("st_w_held1", W_VALID, 0);
    chk("st_stall_req1", STALL_REQ, 1);
    tick;
    chk("st_w_held2", W_VALID, 0);
    chk("st_stall_req2", STALL_REQ, 1);
    STALL = 1'b0;
    #1;
    chk("st_drain_stall_req", STALL_REQ, 0);
    tick;
    M_VALID = 1'b0; M_STORE_EN = 1'b0;
    chk("st_ret_valid", W_VALID, 1);
    chk("st_ret_pc", W_PC, 32'h400);
    tick;
    chk("st_still_one_write", writes - w0, 1);
    chk("st_after_valid", W_VALID, 0);

    // reset while a request is outstanding
    w0 = writes;
    drive(32'h500, 1'b1, 5'd0, 32'h0, 1'b1, 32'h0600, 32'h0, F3_SW);
    tick;
    chk("ra_req_up", mem.WVALID, 1);
    RST = 1'b1;
    tick;
    chk("ra_wvalid", mem.WVALID, 0);
    chk("ra_w_valid", W_VALID, 0);
    RST = 1'b0; M_VALID = 1'b0; M_STORE_EN = 1'b0;
    tick;
    chk("ra_no_retire", W_VALID, 0);
    chk("ra_no_write", writes - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
